// File: rtl/riscv_pkg.sv
// Shared core-wide definitions.
// Machine word width used by every memory-facing block.
package riscv_pkg;
  localparam int XLEN = 32;
endpackage

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter onto one fixed-latency memory port.
// Data wins unless fetch has been starved STARVE_MAX cycles.
module mem_arbiter
  import riscv_pkg::*;
#(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            if_req_i,
  input  logic [XLEN-1:0] if_addr_i,
  output logic            if_gnt_o,
  output logic            if_rvalid_o,
  output logic [XLEN-1:0] if_rdata_o,
  input  logic            d_req_i,
  input  logic            d_we_i,
  input  logic [3:0]      d_be_i,
  input  logic [XLEN-1:0] d_addr_i,
  input  logic [XLEN-1:0] d_wdata_i,
  output logic            d_gnt_o,
  output logic            d_rvalid_o,
  output logic [XLEN-1:0] d_rdata_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [3:0]      mem_be_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            stall_if_o,
  output logic            stall_d_o
);

  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);
  localparam logic [3:0] SMAX     = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] lat_cnt_q, lat_cnt_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       we_q, we_d;

  logic done;
  logic free;
  logic gnt_d;
  logic gnt_i;

  // The response cycle also counts as idle so a new access can issue.
  assign done  = (state_q != IDLE) && (lat_cnt_q == 3'd0);
  assign free  = (state_q == IDLE) || done;
  assign gnt_d = rstn_i && free && d_req_i
              && (starve_cnt_q < SMAX);
  assign gnt_i = rstn_i && free && if_req_i && !gnt_d;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      lat_cnt_q    <= 3'd0;
      starve_cnt_q <= 4'd0;
      we_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      we_q         <= we_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    we_d         = we_q;
    starve_cnt_d = starve_cnt_q;
    if (state_q != IDLE && lat_cnt_q != 3'd0) begin
      lat_cnt_d = lat_cnt_q - 3'd1;
    end
    if (done) begin
      state_d = IDLE;
    end
    unique case (1'b1)
      gnt_d: begin
        state_d   = BUSY_D;
        lat_cnt_d = LAT_INIT;
        we_d      = d_we_i;
      end
      gnt_i: begin
        state_d   = BUSY_I;
        lat_cnt_d = LAT_INIT;
        we_d      = 1'b0;
      end
      default: ;
    endcase
    if (!if_req_i || gnt_i) begin
      starve_cnt_d = 4'd0;
    end else if (starve_cnt_q != 4'hF) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_comb begin
    if_gnt_o    = gnt_i;
    d_gnt_o     = gnt_d;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    unique case (1'b1)
      gnt_d: begin
        mem_req_o   = 1'b1;
        mem_we_o    = d_we_i;
        mem_be_o    = d_be_i;
        mem_addr_o  = d_addr_i;
        mem_wdata_o = d_wdata_i;
      end
      gnt_i: begin
        mem_req_o   = 1'b1;
        mem_be_o    = 4'hF;
        mem_addr_o  = if_addr_i;
      end
      default: ;
    endcase
    if_rvalid_o = rstn_i && done && (state_q == BUSY_I);
    d_rvalid_o  = rstn_i && done && (state_q == BUSY_D);
    if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    // Stores complete with a zero data word.
    d_rdata_o   = (d_rvalid_o && !we_q) ? mem_rdata_i : '0;
    stall_if_o  = rstn_i
               && ((if_req_i && !gnt_i)
               || (state_q == BUSY_I && !if_rvalid_o));
    stall_d_o   = rstn_i
               && ((d_req_i && !gnt_d)
               || (state_q == BUSY_D && !d_rvalid_o));
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cases plus random traffic
// against a cycle-timestamp reference model.
module tb_mem_arbiter;
  import riscv_pkg::*;

  localparam int SMAX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rstn, if_req, d_req, d_we;
  logic [3:0]      d_be;
  logic [XLEN-1:0] if_addr, d_addr, d_wdata, mem_rdata;

  logic            a_ig, a_irv, a_dg, a_drv, a_mreq, a_mwe, a_si, a_sd;
  logic [3:0]      a_mbe;
  logic [XLEN-1:0] a_ird, a_drd, a_maddr, a_mwd;
  logic            b_ig, b_irv, b_dg, b_drv, b_mreq, b_mwe, b_si, b_sd;
  logic [3:0]      b_mbe;
  logic [XLEN-1:0] b_ird, b_drd, b_maddr, b_mwd;

  mem_arbiter #(.MEM_LAT(2), .STARVE_MAX(SMAX)) u_dut (
    .clk_i(clk), .rstn_i(rstn),
    .if_req_i(if_req), .if_addr_i(if_addr),
    .if_gnt_o(a_ig), .if_rvalid_o(a_irv), .if_rdata_o(a_ird),
    .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be),
    .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_gnt_o(a_dg), .d_rvalid_o(a_drv), .d_rdata_o(a_drd),
    .mem_req_o(a_mreq), .mem_we_o(a_mwe), .mem_be_o(a_mbe),
    .mem_addr_o(a_maddr), .mem_wdata_o(a_mwd),
    .mem_rdata_i(mem_rdata),
    .stall_if_o(a_si), .stall_d_o(a_sd)
  );

  mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(SMAX)) u_dut1 (
    .clk_i(clk), .rstn_i(rstn),
    .if_req_i(if_req), .if_addr_i(if_addr),
    .if_gnt_o(b_ig), .if_rvalid_o(b_irv), .if_rdata_o(b_ird),
    .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be),
    .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_gnt_o(b_dg), .d_rvalid_o(b_drv), .d_rdata_o(b_drd),
    .mem_req_o(b_mreq), .mem_we_o(b_mwe), .mem_be_o(b_mbe),
    .mem_addr_o(b_maddr), .mem_wdata_o(b_mwd),
    .mem_rdata_i(mem_rdata),
    .stall_if_o(b_si), .stall_d_o(b_sd)
  );

  int checks = 0;
  int errors = 0;

  bit sel;
  int cyc, lat, nfree, rcyc, starve;
  bit own_d, own_we, out_i, out_d;

  logic            s_ig, s_irv, s_dg, s_drv, s_mreq, s_mwe, s_si, s_sd;
  logic [3:0]      s_mbe;
  logic [XLEN-1:0] s_ird, s_drd, s_maddr, s_mwd, s_mrd;

  task automatic chk(string tag, logic [XLEN-1:0] obs,
                     logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit rs, fr, eig, edg, eirv, edrv;
    logic [XLEN-1:0] ea, ew;
    logic [3:0] eb;
    logic ewe;
    mem_rdata = $urandom();
    @(negedge clk);
    s_ig   = sel ? b_ig   : a_ig;
    s_irv  = sel ? b_irv  : a_irv;
    s_ird  = sel ? b_ird  : a_ird;
    s_dg   = sel ? b_dg   : a_dg;
    s_drv  = sel ? b_drv  : a_drv;
    s_drd  = sel ? b_drd  : a_drd;
    s_mreq = sel ? b_mreq : a_mreq;
    s_mwe  = sel ? b_mwe  : a_mwe;
    s_mbe  = sel ? b_mbe  : a_mbe;
    s_maddr = sel ? b_maddr : a_maddr;
    s_mwd  = sel ? b_mwd  : a_mwd;
    s_si   = sel ? b_si   : a_si;
    s_sd   = sel ? b_sd   : a_sd;
    s_mrd  = mem_rdata;
    rs   = rstn;
    fr   = cyc >= nfree;
    edg  = rs && fr && d_req && (starve < SMAX);
    eig  = rs && fr && if_req && !edg;
    eirv = rs && (cyc == rcyc) && !own_d;
    edrv = rs && (cyc == rcyc) && own_d;
    ea   = edg ? d_addr : (eig ? if_addr : '0);
    ew   = edg ? d_wdata : '0;
    eb   = edg ? d_be : (eig ? 4'hF : 4'h0);
    ewe  = edg && d_we;
    chk("if_gnt", s_ig, eig);
    chk("d_gnt", s_dg, edg);
    chk("mem_req", s_mreq, edg || eig);
    chk("mem_addr", s_maddr, ea);
    chk("mem_we", s_mwe, ewe);
    chk("mem_be", s_mbe, eb);
    chk("mem_wdata", s_mwd, ew);
    chk("if_rvalid", s_irv, eirv);
    chk("d_rvalid", s_drv, edrv);
    chk("if_rdata", s_ird, eirv ? mem_rdata : '0);
    chk("d_rdata", s_drd, (edrv && !own_we) ? mem_rdata : '0);
    chk("stall_if", s_si,
        rs && ((if_req && !eig) || (out_i && !eirv)));
    chk("stall_d", s_sd,
        rs && ((d_req && !edg) || (out_d && !edrv)));
    @(posedge clk);
    if (!rs) begin
      nfree = 0; rcyc = -1; out_i = 0; out_d = 0; starve = 0;
    end else begin
      if (eirv) out_i = 0;
      if (edrv) out_d = 0;
      if (!if_req || eig) starve = 0;
      else if (starve < 15) starve++;
      if (edg || eig) begin
        nfree = cyc + lat; rcyc = cyc + lat;
        own_d = edg; own_we = ewe; out_i = eig; out_d = edg;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle(int n);
    if_req = 0; d_req = 0; d_we = 0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic rand_run(int n);
    for (int i = 0; i < n; i++) begin
      cycle();
      if (!if_req || s_ig) begin
        if_req  = 1'($urandom_range(0, 1));
        if_addr = $urandom() & 32'hFFFF_FFFC;
      end
      if (!d_req || s_dg) begin
        d_req   = 1'($urandom_range(0, 1));
        d_we    = 1'($urandom_range(0, 1));
        d_be    = 4'($urandom_range(1, 15));
        d_addr  = $urandom();
        d_wdata = $urandom();
      end
      rstn = ($urandom_range(0, 63) != 0);
    end
    rstn = 1;
  endtask

  initial begin
    int k;
    bit found;
    sel = 0; lat = 2; cyc = 0; nfree = 0; rcyc = -1;
    starve = 0; own_d = 0; own_we = 0; out_i = 0; out_d = 0;
    rstn = 0; if_req = 1; if_addr = 32'h100; d_req = 1;
    d_we = 0; d_be = 4'hF; d_addr = 32'h200; d_wdata = 0;
    mem_rdata = 0;
    #1;
    cycle(); cycle();
    chk("rst_gnt", s_ig | s_dg, 0);
    chk("rst_memreq", s_mreq, 0);
    chk("rst_stall", s_si | s_sd, 0);
    rstn = 1;
    idle(1);

    if_req = 1; if_addr = 32'h100;
    cycle();
    chk("t29_gnt", s_ig, 1);
    chk("t29_addr", s_maddr, 32'h100);
    if_req = 0;
    cycle();
    chk("t29_rv_early", s_irv, 0);
    cycle();
    chk("t29_rv", s_irv, 1);
    chk("t29_rdata", s_ird, s_mrd);
    idle(1);

    if_req = 1; if_addr = 32'h40;
    d_req = 1; d_we = 0; d_addr = 32'h2000;
    cycle();
    chk("t30_dgnt", s_dg, 1);
    chk("t30_igntlo", s_ig, 0);
    chk("t30_stall0", s_si, 1);
    d_req = 0;
    cycle();
    chk("t30_stall1", s_si, 1);
    cycle();
    chk("t30_igrant", s_ig, 1);
    chk("t30_drv", s_drv, 1);
    if_req = 0;
    cycle(); cycle();
    chk("t30_irv", s_irv, 1);
    idle(1);

    if_req = 1; if_addr = 32'h80;
    d_req = 1; d_addr = 32'h3000;
    found = 0; k = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      if (s_ig) begin found = 1; k = i; end
    end
    chk("t31_found", found, 1);
    chk("t31_cycle", k, 4);
    chk("t31_dlo", s_dg, 0);
    idle(4);

    d_req = 1; d_we = 1; d_be = 4'b0011;
    d_addr = 32'h44; d_wdata = 32'hDEADBEEF;
    cycle();
    chk("t32_we", s_mwe, 1);
    chk("t32_be", s_mbe, 4'b0011);
    chk("t32_wd", s_mwd, 32'hDEADBEEF);
    d_req = 0; d_we = 0;
    cycle(); cycle();
    chk("t32_rv", s_drv, 1);
    chk("t32_rd", s_drd, 0);
    idle(1);

    d_req = 1; d_addr = 32'h500;
    cycle();
    chk("t33_dgnt", s_dg, 1);
    d_req = 0; rstn = 0; if_req = 1; if_addr = 32'h600;
    cycle();
    rstn = 1;
    cycle();
    chk("t33_ignt", s_ig, 1);
    chk("t33_nodrv", s_drv, 0);
    idle(3);

    rand_run(300);
    idle(3);

    sel = 1; lat = 1; rstn = 0;
    idle(1);
    rstn = 1;
    if_req = 1;
    for (int i = 0; i < 6; i++) begin
      if_addr = 32'h1000 + 32'(i * 4);
      cycle();
      chk("t34_gnt", s_ig, 1);
      chk("t34_stall", s_si, 0);
      if (i > 0) chk("t34_rv", s_irv, 1);
    end
    if_req = 0;
    cycle();
    chk("t34_last_rv", s_irv, 1);
    rand_run(200);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
